grid_sched: RTL and testbench
=============================

# grid_sched

Command-driven scheduler that sequences an array of lif cells. It clears the array, steps it for a programmed number of cycles or free-runs it, and injects one edge stimulus pattern per command. It also counts enabled cycles in which the monitored array edge is active. It sits between the host/test interface (one command port) and the array's shared `grid_en`/`grid_rst_n`/injection lanes.

## Interface
Parameters:
- `CNT_W`, 8: width of step argument and activity counter
- `LANES`, 4: width of injection pattern and observed edge bus

Ports:
- `clk`  in  1  clock
- `rst_n`  in  1  reset, synchronous, active-low
- `cmd_valid`  in  1  command offered
- `cmd_ready`  out  1  command accepted when `cmd_valid && cmd_ready`
- `cmd_op`  in  2  00 CLEAR, 01 STEP, 10 RUN, 11 INJECT
- `cmd_arg`  in  CNT_W  STEP count (STEP); pattern in `[LANES-1:0]` (INJECT); ignored otherwise
- `grid_rst_n`  out  1  array reset, active-low
- `grid_en`  out  1  array advances on cycles where high
- `inj_valid`  out  1  injection lanes valid
- `inj_data`  out  LANES  injection pattern
- `obs_in`  in  LANES  monitored array edge output
- `act_cnt`  out  CNT_W  saturating activity count
- `busy`  out  1  state != IDLE
- `done`  out  1  one-cycle pulse at command completion

## Operation
- States: IDLE, CLEAR, STEP, FREE, INJECT. All outputs are registered.
- IDLE: `cmd_ready`=1. On accept, go to the state selected by `cmd_op`. Latch `cmd_arg` into `remain` (STEP) or `pat` (INJECT).
- CLEAR: `grid_rst_n`=0 for exactly 2 cycles, `act_cnt` cleared to 0, `grid_en`=0. Then IDLE with `done`.
- STEP n: `grid_en`=1 for exactly n consecutive cycles while `remain` decrements. For n=0, spend 1 cycle in STEP with `grid_en`=0, then `done`.
- FREE (RUN): `grid_en`=1 every cycle and `cmd_ready`=1. Any accepted command halts the run and is consumed; it is not executed. `grid_en` drops the cycle after acceptance, and `done` pulses in that same cycle.
- INJECT: one cycle with `grid_en`=1, `inj_valid`=1, `inj_data`=`pat`. Then IDLE with `done`. `inj_data`=0 whenever `inj_valid`=0.
- `cmd_ready`=0 in CLEAR, STEP and INJECT. Commands offered there are held off, not dropped.
- Activity counter: increments on every cycle with `grid_en`=1 and `obs_in`!=0. It saturates at 2^CNT_W−1. Only CLEAR or `rst_n` resets it.
- `busy`=1 exactly when the state is not IDLE.

## Timing
- Reset (rst_n=0 at posedge): state IDLE, `grid_rst_n`=0, `grid_en`=0, `inj_valid`=0, `inj_data`=0, `act_cnt`=0, `done`=0. `cmd_ready`=1 and `grid_rst_n`=1 from the first cycle after release.
- Command accepted at edge k: the new state's outputs are visible from cycle k+1.
- STEP n≥1: `grid_en` is high in cycles k+1..k+n. `done` and `cmd_ready` are high in cycle k+n+1.
- INJECT: enable/inject in cycle k+1. `done` in k+2.
- CLEAR: `grid_rst_n` low in k+1 and k+2. `done` in k+3.
- `done` coincides with the first IDLE cycle. A new command can be accepted in that same cycle, giving back-to-back commands with no gap.
- `act_cnt` reflects an enabled cycle on the following cycle.
- `rst_n` low mid-command aborts immediately to the reset values, with no `done`.

## Structure
- Package `grid_pkg`: `cmd_op` encodings (CLEAR/STEP/RUN/INJECT) and the state enum.
- Sub-module `sat_counter`: parameterised width, with `clr`, `inc` and saturating count output. It implements `act_cnt`.
- The FSM, `remain` down-counter and `pat` register stay in the top level.

## Test plan
- Reset release, then STEP 3 with `obs_in`=4'b0100 constant: `grid_en` high exactly 3 cycles, `done` in cycle 4, `act_cnt`=3.
- STEP 0: `busy` for 1 cycle, no `grid_en`, `done` 2 cycles after acceptance, `act_cnt` unchanged.
- INJECT arg=8'h05: one cycle with `inj_valid`=1, `inj_data`=4'b0101, `grid_en`=1. Then `done`, and `inj_data` returns to 0.
- RUN with `obs_in`=4'b0001 for 300 cycles, then any command: `act_cnt` saturates at 255, `grid_en` drops the cycle after halt acceptance, `done` pulses, and the halting command is not executed.
- CLEAR after activity: `grid_rst_n` low exactly 2 cycles, `act_cnt`=0, `done` in cycle 3. A STEP 1 held at `cmd_valid` during CLEAR is accepted in the `done` cycle.
- `rst_n` asserted mid STEP 10: all outputs return to reset values next edge, no `done`, and `act_cnt`=0.

Source files
------------

// File: rtl/grid_sched_pkg.sv
// Shared command encodings and FSM state codes for the lif-array scheduler.
package grid_pkg;

    typedef enum logic [1:0] {
        OP_CLEAR  = 2'b00,
        OP_STEP   = 2'b01,
        OP_RUN    = 2'b10,
        OP_INJECT = 2'b11
    } cmd_op_e;

    typedef logic [2:0] state_t;

    localparam state_t ST_IDLE   = 3'd0;
    localparam state_t ST_CLEAR  = 3'd1;
    localparam state_t ST_STEP   = 3'd2;
    localparam state_t ST_FREE   = 3'd3;
    localparam state_t ST_INJECT = 3'd4;

endpackage

// File: rtl/grid_sched_if.sv
// Command port plus array-side lanes of the scheduler; slave is the scheduler itself.
interface grid_sched_if #(
    parameter int CNT_W = 8,
    parameter int LANES = 4
);
    logic             cmd_valid;
    logic             cmd_ready;
    logic [1:0]       cmd_op;
    logic [CNT_W-1:0] cmd_arg;
    logic             grid_rst_n;
    logic             grid_en;
    logic             inj_valid;
    logic [LANES-1:0] inj_data;
    logic [LANES-1:0] obs_in;
    logic [CNT_W-1:0] act_cnt;
    logic             busy;
    logic             done;

    modport master (
        output cmd_valid, cmd_op, cmd_arg, obs_in,
        input  cmd_ready, grid_rst_n, grid_en, inj_valid, inj_data, act_cnt, busy, done
    );

    modport slave (
        input  cmd_valid, cmd_op, cmd_arg, obs_in,
        output cmd_ready, grid_rst_n, grid_en, inj_valid, inj_data, act_cnt, busy, done
    );
endinterface

// File: rtl/grid_sched_sat_counter.sv
// Saturating up-counter with synchronous clear; clear wins over increment.
module sat_counter #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] cnt
);
    logic [W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr)
            cnt_d = '0;
        else if (inc && (cnt_q != {W{1'b1}}))
            cnt_d = cnt_q + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (!rst_n)
            cnt_q <= '0;
        else
            cnt_q <= cnt_d;
    end

    assign cnt = cnt_q;
endmodule

// File: rtl/grid_sched.sv
// Command FSM that clears, steps, free-runs and injects into the lif array.
// Every output is a flop loaded from the value implied by the next state.
import grid_pkg::*;

module grid_sched #(
    parameter int CNT_W = 8,
    parameter int LANES = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    grid_sched_if.slave  bus
);
    state_t           state_q, state_d;
    logic [CNT_W-1:0] remain_q, remain_d;
    logic [LANES-1:0] pat_q, pat_d;
    logic             cmd_ready_q, cmd_ready_d;
    logic             grid_rst_n_q, grid_rst_n_d;
    logic             grid_en_q, grid_en_d;
    logic             inj_valid_q, inj_valid_d;
    logic [LANES-1:0] inj_data_q, inj_data_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             accept;
    logic             cnt_clr;
    logic             cnt_inc;

    assign accept = bus.cmd_valid && cmd_ready_q;

    always_comb begin
        state_d  = state_q;
        remain_d = remain_q;
        pat_d    = pat_q;
        done_d   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    case (cmd_op_e'(bus.cmd_op))
                        OP_CLEAR: begin
                            state_d  = ST_CLEAR;
                            remain_d = CNT_W'(1);   // two reset cycles: counts 1 then 0
                        end
                        OP_STEP: begin
                            state_d  = ST_STEP;
                            remain_d = bus.cmd_arg;
                        end
                        OP_RUN:    state_d = ST_FREE;
                        default: begin
                            state_d = ST_INJECT;
                            pat_d   = bus.cmd_arg[LANES-1:0];
                        end
                    endcase
                end
            end
            ST_CLEAR: begin
                if (remain_q == '0) begin
                    state_d = ST_IDLE;
                    done_d  = 1'b1;
                end else begin
                    remain_d = remain_q - 1'b1;
                end
            end
            ST_STEP: begin
                // remain_q counts enabled cycles left, including the current one
                if (remain_q <= CNT_W'(1)) begin
                    state_d = ST_IDLE;
                    done_d  = 1'b1;
                end else begin
                    remain_d = remain_q - 1'b1;
                end
            end
            ST_FREE: begin
                if (accept) begin
                    state_d = ST_IDLE;
                    done_d  = 1'b1;
                end
            end
            ST_INJECT: begin
                state_d = ST_IDLE;
                done_d  = 1'b1;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        grid_en_d    = (state_d == ST_FREE) || (state_d == ST_INJECT) ||
                       ((state_d == ST_STEP) && (remain_d != '0));
        grid_rst_n_d = (state_d != ST_CLEAR);
        inj_valid_d  = (state_d == ST_INJECT);
        inj_data_d   = inj_valid_d ? pat_d : '0;
        cmd_ready_d  = (state_d == ST_IDLE) || (state_d == ST_FREE);
        busy_d       = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            remain_q     <= '0;
            pat_q        <= '0;
            cmd_ready_q  <= 1'b0;
            grid_rst_n_q <= 1'b0;
            grid_en_q    <= 1'b0;
            inj_valid_q  <= 1'b0;
            inj_data_q   <= '0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            remain_q     <= remain_d;
            pat_q        <= pat_d;
            cmd_ready_q  <= cmd_ready_d;
            grid_rst_n_q <= grid_rst_n_d;
            grid_en_q    <= grid_en_d;
            inj_valid_q  <= inj_valid_d;
            inj_data_q   <= inj_data_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
        end
    end

    // Clearing from the accept edge onward makes act_cnt read 0 throughout CLEAR.
    assign cnt_clr = (state_d == ST_CLEAR);
    assign cnt_inc = grid_en_q && (bus.obs_in != '0);

    sat_counter #(.W(CNT_W)) u_act_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (cnt_clr),
        .inc   (cnt_inc),
        .cnt   (bus.act_cnt)
    );

    assign bus.cmd_ready  = cmd_ready_q;
    assign bus.grid_rst_n = grid_rst_n_q;
    assign bus.grid_en    = grid_en_q;
    assign bus.inj_valid  = inj_valid_q;
    assign bus.inj_data   = inj_data_q;
    assign bus.busy       = busy_q;
    assign bus.done       = done_q;
endmodule

// File: tb/tb_grid_sched.sv
// Directed bench for grid_sched: a command table plus hand-built RUN, CLEAR-hold and reset-abort sequences.
module tb_grid_sched;
    logic clk = 1'b0;
    logic rst_n = 1'b0;

    grid_sched_if #(.CNT_W(8), .LANES(4)) bus ();

    grid_sched #(.CNT_W(8), .LANES(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    int vec_cnt = 0;
    int err_cnt = 0;

    typedef struct {
        logic [1:0] op;
        logic [7:0] arg;
        logic [3:0] obs;
        int         en;
        int         rstlow;
        int         inj;
        int         inj_data;
        int         done_lat;
        int         act;
    } vec_t;

    vec_t tbl [8];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input int got, input int exp);
        vec_cnt++;
        if (got != exp) begin
            err_cnt++;
            $display("FAIL %s: got %0d, expected %0d", name, got, exp);
        end
    endtask

    // Offers a command until accepted; returns one cycle after the acceptance edge.
    task automatic issue(input logic [1:0] op, input logic [7:0] arg);
        int w;
        bus.cmd_valid = 1'b1;
        bus.cmd_op    = op;
        bus.cmd_arg   = arg;
        w = 0;
        while (!bus.cmd_ready && w < 50) begin
            tick();
            w++;
        end
        if (!bus.cmd_ready) check("accept_timeout", 0, 1);
        tick();
        bus.cmd_valid = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int en_n, rl_n, inj_n, inj_d, bad_idle, lat;
        tbl[0] = '{2'b00, 8'h00, 4'h0, 0, 2, 0, 0,  3, 0};
        tbl[1] = '{2'b01, 8'd3,  4'h4, 3, 0, 0, 0,  4, 3};
        tbl[2] = '{2'b01, 8'd0,  4'h4, 0, 0, 0, 0,  2, 3};
        tbl[3] = '{2'b11, 8'h05, 4'h0, 1, 0, 1, 5,  2, 3};
        tbl[4] = '{2'b11, 8'hFA, 4'h2, 1, 0, 1, 10, 2, 4};
        tbl[5] = '{2'b01, 8'd1,  4'h0, 1, 0, 0, 0,  2, 4};
        tbl[6] = '{2'b01, 8'd5,  4'h1, 5, 0, 0, 0,  6, 9};
        tbl[7] = '{2'b00, 8'h00, 4'h3, 0, 2, 0, 0,  3, 0};

        bus.cmd_valid = 1'b0;
        bus.cmd_op    = 2'b00;
        bus.cmd_arg   = '0;
        bus.obs_in    = '0;

        // Reset values
        tick();
        tick();
        check("rst_grid_rst_n", int'(bus.grid_rst_n), 0);
        check("rst_grid_en",    int'(bus.grid_en),    0);
        check("rst_inj_valid",  int'(bus.inj_valid),  0);
        check("rst_inj_data",   int'(bus.inj_data),   0);
        check("rst_act_cnt",    int'(bus.act_cnt),    0);
        check("rst_done",       int'(bus.done),       0);
        check("rst_busy",       int'(bus.busy),       0);
        rst_n = 1'b1;
        tick();
        check("rel_cmd_ready",  int'(bus.cmd_ready),  1);
        check("rel_grid_rst_n", int'(bus.grid_rst_n), 1);
        $display("reset released");

        // Table of single commands, issued back to back
        for (int r = 0; r < 8; r++) begin
            bus.obs_in = tbl[r].obs;
            issue(tbl[r].op, tbl[r].arg);
            en_n = 0; rl_n = 0; inj_n = 0; inj_d = 0; bad_idle = 0; lat = 0;
            check($sformatf("r%0d_busy", r), int'(bus.busy), 1);
            for (int j = 1; j <= 20; j++) begin
                if (bus.grid_en)     en_n++;
                if (!bus.grid_rst_n) rl_n++;
                if (bus.inj_valid) begin
                    inj_n++;
                    inj_d = int'(bus.inj_data);
                end else if (bus.inj_data != '0) begin
                    bad_idle++;
                end
                if (bus.done) begin
                    lat = j;
                    break;
                end
                tick();
            end
            check($sformatf("r%0d_en_cycles", r),  en_n,     tbl[r].en);
            check($sformatf("r%0d_rst_cycles", r), rl_n,     tbl[r].rstlow);
            check($sformatf("r%0d_inj_cycles", r), inj_n,    tbl[r].inj);
            check($sformatf("r%0d_inj_data", r),   inj_d,    tbl[r].inj_data);
            check($sformatf("r%0d_inj_idle", r),   bad_idle, 0);
            check($sformatf("r%0d_done_lat", r),   lat,      tbl[r].done_lat);
            check($sformatf("r%0d_act_cnt", r),    int'(bus.act_cnt), tbl[r].act);
            $display("row %0d op=%0d arg=%0d: en=%0d rst=%0d inj=%0d done_lat=%0d act=%0d",
                     r, tbl[r].op, tbl[r].arg, en_n, rl_n, inj_n, lat, bus.act_cnt);
        end

        // RUN until saturation, then halt with a STEP that must not execute
        bus.obs_in = 4'b0001;
        issue(2'b10, 8'h00);
        en_n = 0; rl_n = 0;
        for (int j = 0; j < 300; j++) begin
            if (!bus.grid_en)   en_n++;
            if (!bus.cmd_ready) rl_n++;
            tick();
        end
        check("run_en_gaps",    en_n, 0);
        check("run_not_ready",  rl_n, 0);
        check("run_act_sat",    int'(bus.act_cnt), 255);
        bus.cmd_valid = 1'b1;
        bus.cmd_op    = 2'b01;
        bus.cmd_arg   = 8'd3;
        tick();
        bus.cmd_valid = 1'b0;
        check("halt_grid_en",   int'(bus.grid_en), 0);
        check("halt_done",      int'(bus.done),    1);
        check("halt_busy",      int'(bus.busy),    0);
        tick();
        check("halt_no_exec_en",   int'(bus.grid_en), 0);
        check("halt_no_exec_busy", int'(bus.busy),    0);
        check("halt_done_pulse",   int'(bus.done),    0);
        check("halt_act_sat",      int'(bus.act_cnt), 255);
        $display("run/halt: act=%0d", bus.act_cnt);

        // CLEAR with a STEP 1 held off until the done cycle
        issue(2'b00, 8'h00);
        bus.obs_in    = 4'b0000;
        bus.cmd_valid = 1'b1;
        bus.cmd_op    = 2'b01;
        bus.cmd_arg   = 8'd1;
        check("clr_c1_rst_n", int'(bus.grid_rst_n), 0);
        check("clr_c1_ready", int'(bus.cmd_ready),  0);
        tick();
        check("clr_c2_rst_n", int'(bus.grid_rst_n), 0);
        check("clr_c2_act",   int'(bus.act_cnt),    0);
        tick();
        check("clr_c3_done",  int'(bus.done),       1);
        check("clr_c3_rst_n", int'(bus.grid_rst_n), 1);
        check("clr_c3_ready", int'(bus.cmd_ready),  1);
        tick();
        bus.cmd_valid = 1'b0;
        check("held_step_en",   int'(bus.grid_en), 1);
        check("held_step_busy", int'(bus.busy),    1);
        tick();
        check("held_step_done", int'(bus.done),    1);
        check("held_step_off",  int'(bus.grid_en), 0);
        $display("clear + held step: act=%0d", bus.act_cnt);

        // Reset asserted in the middle of STEP 10
        bus.obs_in = 4'b1000;
        issue(2'b01, 8'd10);
        tick();
        tick();
        tick();
        check("abort_pre_act", int'(bus.act_cnt), 3);
        rst_n = 1'b0;
        tick();
        check("abort_grid_en",   int'(bus.grid_en),    0);
        check("abort_grid_rst",  int'(bus.grid_rst_n), 0);
        check("abort_inj_valid", int'(bus.inj_valid),  0);
        check("abort_busy",      int'(bus.busy),       0);
        check("abort_done",      int'(bus.done),       0);
        check("abort_act",       int'(bus.act_cnt),    0);
        tick();
        check("abort_done_hold", int'(bus.done), 0);
        rst_n = 1'b1;
        tick();
        check("abort_rel_ready", int'(bus.cmd_ready), 1);
        check("abort_rel_done",  int'(bus.done),      0);
        $display("reset abort: act=%0d", bus.act_cnt);

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end
endmodule
